// File: rtl/downcounter_ld.sv
// Loadable N-bit down counter with borrow pulse and IDLE/COUNT control.
// Define DOWNCOUNTER_AUTO_RELOAD_EN to reload from the reload register at terminal count.
module downcounter_ld #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] ldval,
  input  logic         cnten,
  output logic [N-1:0] out,
  output logic         zero,
  output logic         bo,
  output logic         busy
);

  typedef enum logic {
    IDLE,
    COUNT
  } state_t;

  state_t       state, state_n;
  logic [N-1:0] rld, rld_n;
  logic [N-1:0] cnt_n;
  logic [N-1:0] dec;
  logic         bo_n;
  logic         term;
  logic         reload;
  logic         brw;

  // Half-subtractor chain: bit i flips when every lower bit is 0.
  always_comb begin
    brw = cnten;
    dec = out;
    for (int i = 0; i < N; i++) begin
      dec[i] = out[i] ^ brw;
      brw    = brw & ~out[i];
    end
  end

  assign term = (state == COUNT) && cnten && (out == N'(1));

`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
  assign reload = term && (rld != '0);
`else
  assign reload = 1'b0;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = out;
    rld_n   = rld;
    bo_n    = 1'b0;
    if (ld) begin
      cnt_n   = ldval;
      rld_n   = ldval;
      state_n = (ldval != '0) ? COUNT : IDLE;
    end else if (term) begin
      bo_n = 1'b1;
      if (reload) begin
        cnt_n = rld;
      end else begin
        cnt_n   = '0;
        state_n = IDLE;
      end
    end else if (state == COUNT) begin
      cnt_n = dec;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      out   <= '0;
      rld   <= '0;
      bo    <= 1'b0;
    end else begin
      state <= state_n;
      out   <= cnt_n;
      rld   <= rld_n;
      bo    <= bo_n;
    end
  end

  assign zero = (out == '0);
  assign busy = (state == COUNT);

endmodule

// File: tb/tb_downcounter_ld.sv
// Bench for downcounter_ld: directed test-plan steps plus random traffic
// checked against an arithmetic reference model.
module tb_downcounter_ld;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         ld = 1'b0;
  logic [N-1:0] ldval = '0;
  logic         cnten = 1'b0;
  logic [N-1:0] out;
  logic         zero;
  logic         bo;
  logic         busy;

  int tests = 0;
  int fails = 0;

  int m_cnt = 0;
  int m_rld = 0;
  int m_bo = 0;
  int m_busy = 0;

`ifdef DOWNCOUNTER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  downcounter_ld #(.N(N)) dut (
    .clk   (clk),
    .clr   (clr),
    .ld    (ld),
    .ldval (ldval),
    .cnten (cnten),
    .out   (out),
    .zero  (zero),
    .bo    (bo),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    tests++;
    assert (got === 32'(exp)) else begin
      fails++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic void model(input bit c, input bit l, input int v, input bit e);
    if (c) begin
      m_cnt = 0; m_rld = 0; m_bo = 0; m_busy = 0;
    end else if (l) begin
      m_cnt = v; m_rld = v; m_bo = 0; m_busy = (v != 0) ? 1 : 0;
    end else if (m_busy != 0 && e) begin
      if (m_cnt == 1) begin
        m_bo = 1;
        if (AUTO && m_rld != 0) m_cnt = m_rld;
        else begin m_cnt = 0; m_busy = 0; end
      end else begin
        m_cnt = m_cnt - 1; m_bo = 0;
      end
    end else begin
      m_bo = 0;
    end
  endfunction

  task automatic step(input bit c, input bit l, input int v, input bit e);
    clr = c; ld = l; ldval = N'(v); cnten = e;
    @(posedge clk);
    #1;
    model(c, l, v, e);
    chk("out", 32'(out), m_cnt);
    chk("zero", 32'(zero), (m_cnt == 0) ? 1 : 0);
    chk("bo", 32'(bo), m_bo);
    chk("busy", 32'(busy), m_busy);
  endtask

  initial begin
    // reset overrides load
    step(1, 1, 9, 0);
    step(1, 1, 9, 1);
    chk("rst_out", 32'(out), 0);
    chk("rst_zero", 32'(zero), 1);

    // one-shot from 3
    step(0, 1, 3, 1);
    chk("os_ld", 32'(out), 3);
    step(0, 0, 0, 1);
    chk("os_2", 32'(out), 2);
    step(0, 0, 0, 1);
    chk("os_1_bo", 32'(bo), 0);
    step(0, 0, 0, 1);
    chk("os_0", 32'(out), AUTO ? 3 : 0);
    chk("os_bo", 32'(bo), 1);
    step(0, 0, 0, 1);
    chk("os_bo_off", 32'(bo), 0);
    step(0, 1, 0, 0);

    // hold pattern then load wins mid-count
    step(0, 1, 5, 0);
    step(0, 0, 0, 1);
    chk("hold_4", 32'(out), 4);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("hold_keep", 32'(out), 4);
    step(0, 0, 0, 1);
    chk("hold_3", 32'(out), 3);
    step(0, 1, 12, 1);
    chk("ld_wins", 32'(out), 12);

    // full-width count down
    step(0, 1, 15, 0);
    for (int i = 0; i < 15; i++) step(0, 0, 0, 1);
    chk("w15_bo", 32'(bo), 1);
    step(0, 1, 0, 1);
    chk("ld0_busy", 32'(busy), 0);
    chk("ld0_zero", 32'(zero), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("ld0_nowrap", 32'(out), 0);

    // auto reload period 2
    step(0, 1, 2, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
    chk("ar_busy", 32'(busy), AUTO ? 1 : 0);

    // mid-operation reset clears reload register
    step(0, 1, 7, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    chk("mid_4", 32'(out), 4);
    step(1, 0, 0, 1);
    chk("mid_clr", 32'(out), 0);
    step(0, 0, 0, 1);
    chk("mid_noreload", 32'(out), 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 6) == 0),
           int'($urandom_range(0, (1 << N) - 1)),
           ($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
